rr_onehot_arbiter: RTL and testbench
====================================

RR_ONEHOT_ARBITER -- requirements
Module: rr_onehot_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 8, number of requesters (2..16).
REQ-002 SHALL have parameter MAX_HOLD, default 16, maximum consecutive grant cycles per tenure (>=1).
REQ-003 SHALL have local width ID_W = $clog2(NUM_REQ).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_i  input  NUM_REQ  request vector, bit i = requester i.
REQ-007 SHALL have port gnt_onehot_o  output  NUM_REQ  registered one-hot grant, all-zero when idle.
REQ-008 SHALL have port gnt_bin_o  output  ID_W  binary index of the granted requester, 0 when idle.
REQ-009 SHALL have port gnt_valid_o  output  1  high while a grant is held.
REQ-010 SHALL have port timeout_o  output  1  one-cycle pulse on forced release at MAX_HOLD.

Function
REQ-011 SHALL implement two states: IDLE (no grant) and BUSY (grant held by owner).
REQ-012 SHALL keep a round-robin pointer ptr (ID_W bits); candidate search order SHALL be ptr, ptr+1, ... wrapping modulo NUM_REQ.
REQ-013 In IDLE with req_i != 0 sampled at an edge, SHALL grant the first set bit in search order at that edge and enter BUSY, giving 1-cycle latency from req to gnt_valid_o.
REQ-014 In IDLE with req_i == 0, SHALL stay IDLE with all grant outputs 0.
REQ-015 SHALL keep a hold counter that is 1 in the first grant cycle of a tenure and increments each BUSY cycle.
REQ-016 In BUSY, SHALL keep the grant unchanged while req_i[owner]=1 and hold count < MAX_HOLD.
REQ-017 SHALL release when req_i[owner]=0 is sampled (voluntary) or when hold count == MAX_HOLD with req_i[owner]=1 (forced).
REQ-018 At release, SHALL set ptr = (owner+1) mod NUM_REQ; wrap from NUM_REQ-1 to 0 is required.
REQ-019 At release, SHALL re-arbitrate in the same edge using the updated ptr over the current req_i. A hit SHALL register a new grant with no idle gap and restart the hold count at 1. No hit SHALL enter IDLE.
REQ-020 On forced release, the owner SHALL be re-eligible at lowest priority; if it is the only requester it SHALL be re-granted immediately as a new tenure.
REQ-021 timeout_o SHALL pulse high for exactly the first cycle after a forced release, otherwise 0.
REQ-022 gnt_onehot_o SHALL always be zero or exactly one-hot, and SHALL equal 1<<gnt_bin_o whenever gnt_valid_o=1.
REQ-023 The owner deasserting its req SHALL still see its grant for that one cycle; the grant SHALL drop or move at the next edge.
REQ-024 Requests arriving or leaving from non-owners during BUSY SHALL NOT affect the current grant.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for a clock edge, force state IDLE, ptr=0, hold count=0, gnt_onehot_o=0, gnt_bin_o=0, gnt_valid_o=0, timeout_o=0.
REQ-026 Reset asserted mid-tenure SHALL drop the grant immediately; after release, arbitration SHALL restart from ptr=0.
REQ-027 The first edge after rst deasserts SHALL be a normal arbitration edge.

Verification (NUM_REQ=8, MAX_HOLD=4)
REQ-028 Reset, then req_i=8'b0000_0100 -> next cycle gnt_onehot_o=8'b0000_0100, gnt_bin_o=2, gnt_valid_o=1, timeout_o=0.
REQ-029 req_i=8'hFF held constant from reset -> grant 0 for 4 cycles, timeout_o pulse, then grant 1 for 4 cycles, then 2, and so on through 7 and back to 0, with no gaps.
REQ-030 Owner 3 drops req with req_i bits 1 and 5 set -> next grant 5 (ptr=4); after 5 releases -> grant 1.
REQ-031 Owner 7 releases with bits 0 and 6 pending -> grant 0 (wrap-around); ptr becomes 0.
REQ-032 Only req 2 held for 10 cycles -> grant 2 continuous, timeout_o pulses after cycles 4 and 8, gnt_valid_o never drops.
REQ-033 rst pulsed mid-grant of owner 5 -> all outputs 0 within the same cycle; then req_i=8'h81 -> grant 0.

Source files
------------

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: round-robin arbiter with registered one-hot/binary grant and a bounded hold time per tenure
module rr_onehot_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  output logic [NUM_REQ-1:0]         gnt_onehot_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_bin_o,
  output logic                       gnt_valid_o,
  output logic                       timeout_o
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int HW   = $clog2(MAX_HOLD + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d, gnt_bin_q, gnt_bin_d, hit_idx, nxt_ptr;
  logic [NUM_REQ-1:0]  gnt_onehot_q, gnt_onehot_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                timeout_q, timeout_d;
  logic                owner_req, at_max, rel, forced, rearb, hit;
  int                  idx;
  always_comb begin
    owner_req = req_i[gnt_bin_q];
    at_max    = hold_q == HW'(MAX_HOLD);
    rel       = state_q == BUSY && (!owner_req || at_max);
    forced    = state_q == BUSY && owner_req && at_max;
    nxt_ptr   = (int'(gnt_bin_q) == NUM_REQ - 1) ? '0 : gnt_bin_q + ID_W'(1);
    ptr_d     = rel ? nxt_ptr : ptr_q;
    hit       = 1'b0;
    hit_idx   = '0;
    idx       = 0;
    // descending scan so the nearest requester in search order wins
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_d) + k) % NUM_REQ;
      if (req_i[idx]) begin
        hit     = 1'b1;
        hit_idx = ID_W'(idx);
      end
    end
    rearb        = state_q == IDLE || rel;
    state_d      = rearb ? (hit ? BUSY : IDLE) : BUSY;
    gnt_bin_d    = rearb ? (hit ? hit_idx : '0) : gnt_bin_q;
    gnt_onehot_d = rearb ? (hit ? NUM_REQ'(1) << hit_idx : '0) : gnt_onehot_q;
    hold_d       = rearb ? (hit ? HW'(1) : '0) : hold_q + HW'(1);
    timeout_d    = forced;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_bin_q    <= '0;
      gnt_onehot_q <= '0;
      hold_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_bin_q    <= gnt_bin_d;
      gnt_onehot_q <= gnt_onehot_d;
      hold_q       <= hold_d;
      timeout_q    <= timeout_d;
    end
  end
  assign gnt_onehot_o = gnt_onehot_q;
  assign gnt_bin_o    = gnt_bin_q;
  assign gnt_valid_o  = state_q == BUSY;
  assign timeout_o    = timeout_q;
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb_rr_onehot_arbiter: directed checks of the round-robin arbiter with NUM_REQ=8, MAX_HOLD=4
module tb_rr_onehot_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_i = '0;
  logic [7:0] gnt_onehot_o;
  logic [2:0] gnt_bin_o;
  logic       gnt_valid_o, timeout_o;
  int         n_cmp = 0, n_bad = 0;
  rr_onehot_arbiter #(.NUM_REQ(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .gnt_onehot_o(gnt_onehot_o),
    .gnt_bin_o(gnt_bin_o), .gnt_valid_o(gnt_valid_o), .timeout_o(timeout_o)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask
  task automatic chk(input string tag, input logic v, input logic [2:0] b, input logic t);
    logic [7:0] oh;
    oh = v ? (8'd1 << b) : 8'd0;
    n_cmp += 4;
    assert (gnt_valid_o === v) else begin n_bad++; $error("FAIL %s valid: got %b exp %b", tag, gnt_valid_o, v); end
    assert (gnt_bin_o === (v ? b : 3'd0)) else begin n_bad++; $error("FAIL %s bin: got %0d exp %0d", tag, gnt_bin_o, v ? b : 3'd0); end
    assert (gnt_onehot_o === oh) else begin n_bad++; $error("FAIL %s onehot: got %b exp %b", tag, gnt_onehot_o, oh); end
    assert (timeout_o === t) else begin n_bad++; $error("FAIL %s timeout: got %b exp %b", tag, timeout_o, t); end
  endtask
  initial begin
    #1;
    chk("reset", 1'b0, 3'd0, 1'b0);
    step();
    step();
    rst = 1'b0;
    req_i = 8'b0000_0100;
    step();
    chk("single_req2", 1'b1, 3'd2, 1'b0);
    req_i = 8'h00;
    step();
    chk("owner_drop_idle", 1'b0, 3'd0, 1'b0);
    step();
    chk("stay_idle", 1'b0, 3'd0, 1'b0);
    pulse_rst();
    req_i = 8'hFF;
    for (int o = 0; o < 9; o++)
      for (int c = 0; c < 4; c++) begin
        step();
        chk($sformatf("all_req_o%0d_c%0d", o, c), 1'b1, 3'(o % 8), (c == 0 && o > 0));
      end
    pulse_rst();
    req_i = 8'b0000_1000;
    step();
    chk("own3", 1'b1, 3'd3, 1'b0);
    req_i = 8'b1100_1001;
    step();
    chk("own3_nonowner_noise", 1'b1, 3'd3, 1'b0);
    req_i = 8'b0010_0010;
    step();
    chk("own3_drop_to5", 1'b1, 3'd5, 1'b0);
    req_i = 8'b0000_0010;
    step();
    chk("own5_drop_to1", 1'b1, 3'd1, 1'b0);
    pulse_rst();
    req_i = 8'b1000_0000;
    step();
    chk("own7", 1'b1, 3'd7, 1'b0);
    req_i = 8'b0100_0001;
    step();
    chk("own7_wrap_to0", 1'b1, 3'd0, 1'b0);
    req_i = 8'b0100_0000;
    step();
    chk("own0_drop_to6", 1'b1, 3'd6, 1'b0);
    pulse_rst();
    req_i = 8'b0000_0100;
    for (int n = 1; n <= 10; n++) begin
      step();
      chk($sformatf("hold2_cyc%0d", n), 1'b1, 3'd2, (n == 5 || n == 9));
    end
    pulse_rst();
    req_i = 8'b0010_0000;
    step();
    chk("own5", 1'b1, 3'd5, 1'b0);
    step();
    rst = 1'b1;
    #1;
    chk("async_rst_mid", 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    req_i = 8'h81;
    step();
    chk("after_rst_ptr0", 1'b1, 3'd0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
